// File: rtl/fft_buf_ctrl_if.sv
// Bus bundle for fft_buf_ctrl: FFT sample input, display readout stream,
// spectrum RAM write/read sides and status. The slave modport is the controller's view.
interface fft_buf_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
);
  logic              fft_valid;
  logic              fft_sof;
  logic              fft_last;
  logic [DATA_W-1:0] fft_data;
  logic              scan_start;
  logic              disp_ready;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_last;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic              ram_rd_clk_en;
  logic [DATA_W-1:0] ram_rd_data;
  logic              buf_full;
  logic              busy;
  logic              frame_err;
  logic [7:0]        drop_cnt;

  modport slave (
    input  fft_valid, fft_sof, fft_last, fft_data, scan_start, disp_ready, ram_rd_data,
    output disp_valid, disp_data, disp_addr, disp_last,
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_clk_en,
    output buf_full, busy, frame_err, drop_cnt
  );

  modport master (
    output fft_valid, fft_sof, fft_last, fft_data, scan_start, disp_ready, ram_rd_data,
    input  disp_valid, disp_data, disp_addr, disp_last,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_clk_en,
    input  buf_full, busy, frame_err, drop_cnt
  );
endinterface

// File: rtl/fft_buf_ctrl.sv
// Single-frame spectrum buffer controller: captures one FFT frame into an SDP RAM,
// then streams it to the display with ready-based stalling and 1-cycle RAM latency.
module fft_buf_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_buf_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL, S_SCAN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic [7:0]        r_drop_cnt;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_frame_err;
  logic              w_issue;
  logic              w_drop;
  logic              r_disp_vld_p1;
  logic              r_disp_last_p1;
  logic [ADDR_W-1:0] r_disp_addr_p1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_ptr;
    w_frame_err  = 1'b0;
    w_issue      = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.fft_valid) begin
          if (bus.fft_sof) begin
            w_wr_en      = 1'b1;
            w_wr_addr    = '0;
            w_wr_ptr_nxt = ONE_ADDR;
            w_state_nxt  = S_FILL;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (bus.fft_valid) begin
          w_wr_en = 1'b1;
          // A new sof mid-frame restarts capture; the partial frame is discarded.
          if (bus.fft_sof) begin
            w_wr_addr    = '0;
            w_frame_err  = 1'b1;
            w_wr_ptr_nxt = ONE_ADDR;
          end else if (r_wr_ptr == LAST_ADDR) begin
            w_frame_err  = ~bus.fft_last;
            w_wr_ptr_nxt = '0;
            w_state_nxt  = S_FULL;
          end else if (bus.fft_last) begin
            w_frame_err  = 1'b1;
            w_wr_ptr_nxt = '0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + ONE_ADDR;
          end
        end
      end
      S_FULL: begin
        w_drop = bus.fft_valid;
        if (bus.scan_start) begin
          w_rd_ptr_nxt = '0;
          w_state_nxt  = S_SCAN;
        end
      end
      S_SCAN: begin
        w_drop = bus.fft_valid;
        if (bus.disp_ready) begin
          w_issue      = 1'b1;
          w_rd_ptr_nxt = r_rd_ptr + ONE_ADDR;
          if (r_rd_ptr == LAST_ADDR) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_drop_cnt     <= '0;
      r_disp_vld_p1  <= 1'b0;
      r_disp_last_p1 <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      if (w_drop) begin
        r_drop_cnt <= sat_inc8(r_drop_cnt);
      end
      r_disp_vld_p1  <= w_issue;
      r_disp_last_p1 <= w_issue & (r_rd_ptr == LAST_ADDR);
    end
  end

  // p0 -> p1: issued address travels with the RAM's 1-cycle read latency
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_disp_addr_p1 <= r_rd_ptr;
    end
  end

  // Strobes are masked while reset is held so an aborted FILL/SCAN cannot touch the RAM.
  assign bus.ram_wr_en     = w_wr_en & rst_n;
  assign bus.ram_wr_addr   = w_wr_addr;
  assign bus.ram_wr_data   = bus.fft_data;
  assign bus.ram_rd_addr   = r_rd_ptr;
  assign bus.ram_rd_clk_en = w_issue & rst_n;
  assign bus.disp_valid    = r_disp_vld_p1;
  assign bus.disp_data     = bus.ram_rd_data;
  assign bus.disp_addr     = r_disp_addr_p1;
  assign bus.disp_last     = r_disp_last_p1;
  assign bus.buf_full      = (r_state == S_FULL);
  assign bus.busy          = (r_state == S_FILL) || (r_state == S_SCAN);
  assign bus.frame_err     = w_frame_err & rst_n;
  assign bus.drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_fft_buf_ctrl.sv
// Scoreboard bench for fft_buf_ctrl: directed frames and scans, with a behavioural
// SDP RAM; expected display beats are queued at issue and checked by a monitor.
`timescale 1ns/1ps
module tb_fft_buf_ctrl;

  typedef struct {
    logic [11:0] data;
    logic [7:0]  addr;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_buf_ctrl_if #(.ADDR_W(8), .DATA_W(12)) bus ();

  fft_buf_ctrl #(.ADDR_W(8), .DATA_W(12)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checks     = 0;
  int    failures   = 0;
  int    ferr_cnt   = 0;
  int    beats_seen = 0;
  beat_t exp_q[$];

  logic [11:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    if (bus.ram_rd_clk_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.disp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got addr %0d, required no beat", bus.disp_addr);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(bus.disp_data), 32'(e.data));
        chk("beat_addr", 32'(bus.disp_addr), 32'(e.addr));
        chk("beat_last", 32'(bus.disp_last), 32'(e.last));
        beats_seen++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int last_at, input logic [11:0] key);
    for (int i = 0; i <= last_at; i++) begin
      bus.fft_valid = 1'b1;
      bus.fft_sof   = (i == 0);
      bus.fft_last  = (i == last_at);
      bus.fft_data  = 12'(i) ^ key;
      if (i == 10) begin
        #2;
        chk("fill_wr_en", 32'(bus.ram_wr_en), 32'd1);
        chk("fill_wr_addr", 32'(bus.ram_wr_addr), 32'd10);
        chk("fill_wr_data", 32'(bus.ram_wr_data), 32'(12'd10 ^ key));
      end
      tick();
    end
    bus.fft_valid = 1'b0;
    bus.fft_sof   = 1'b0;
    bus.fft_last  = 1'b0;
  endtask

  task automatic scan(input bit toggle, input int stop_at, input logic [11:0] key, input int flood);
    int    k        = 0;
    int    cyc      = 0;
    int    rden_err = 0;
    int    wr_err   = 0;
    int    seen0    = beats_seen;
    beat_t b;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    while (k < stop_at && cyc < 2000) begin
      bus.disp_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.fft_valid  = (cyc < flood);
      bus.fft_sof    = (cyc < flood) && (cyc % 7 == 0);
      bus.fft_data   = 12'hFFF;
      #2;
      if (bus.ram_rd_clk_en !== bus.disp_ready) rden_err++;
      if (bus.ram_wr_en !== 1'b0) wr_err++;
      if (bus.disp_ready) begin
        b.data = 12'(k) ^ key;
        b.addr = 8'(k);
        b.last = (k == 255);
        exp_q.push_back(b);
        k++;
      end
      tick();
      cyc++;
    end
    bus.fft_valid = 1'b0;
    bus.fft_sof   = 1'b0;
    chk("scan_issued", 32'(k), 32'(stop_at));
    chk("scan_rd_clk_en", 32'(rden_err), 32'd0);
    chk("scan_no_write", 32'(wr_err), 32'd0);
    if (stop_at == 256) begin
      bus.disp_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("scan_beats", 32'(beats_seen - seen0), 32'd256);
      chk("scan_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("scan_end_busy", 32'(bus.busy), 32'd0);
      chk("scan_end_full", 32'(bus.buf_full), 32'd0);
      tick();
    end
  endtask

  initial begin
    int f0;
    int wr_err;
    rst_n          = 1'b0;
    bus.fft_valid  = 1'b0;
    bus.fft_sof    = 1'b0;
    bus.fft_last   = 1'b0;
    bus.fft_data   = '0;
    bus.scan_start = 1'b0;
    bus.disp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_buf_full", 32'(bus.buf_full), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("rst_disp_last", 32'(bus.disp_last), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("rst_rd_clk_en", 32'(bus.ram_rd_clk_en), 32'd0);
    rst_n = 1'b1;

    // scan_start in IDLE does nothing
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    chk("idle_scan_ignored", 32'(bus.busy), 32'd0);

    // full frame capture, then plain readout
    f0 = ferr_cnt;
    send_frame(255, 12'h000);
    chk("frame_buf_full", 32'(bus.buf_full), 32'd1);
    chk("frame_busy", 32'(bus.busy), 32'd0);
    chk("frame_no_err", 32'(ferr_cnt - f0), 32'd0);
    scan(1'b0, 256, 12'h000, 0);

    // stalled readout with ready toggling
    send_frame(255, 12'h3C3);
    scan(1'b1, 256, 12'h3C3, 0);

    // short frame is discarded, then a good frame is accepted
    f0 = ferr_cnt;
    send_frame(99, 12'h000);
    chk("short_err", 32'(ferr_cnt - f0), 32'd1);
    chk("short_busy", 32'(bus.busy), 32'd0);
    chk("short_full", 32'(bus.buf_full), 32'd0);
    send_frame(255, 12'h0F0);
    chk("after_short_full", 32'(bus.buf_full), 32'd1);
    chk("after_short_err", 32'(ferr_cnt - f0), 32'd1);

    // samples while FULL and during SCAN are dropped; drop_cnt saturates
    wr_err = 0;
    for (int i = 0; i < 10; i++) begin
      bus.fft_valid = 1'b1;
      bus.fft_sof   = (i % 3 == 0);
      bus.fft_data  = 12'hFFF;
      #2;
      if (bus.ram_wr_en !== 1'b0) wr_err++;
      tick();
    end
    bus.fft_valid = 1'b0;
    bus.fft_sof   = 1'b0;
    chk("full_no_write", 32'(wr_err), 32'd0);
    chk("full_drop_cnt", 32'(bus.drop_cnt), 32'd10);
    chk("full_held", 32'(bus.buf_full), 32'd1);
    scan(1'b1, 256, 12'h0F0, 300);
    chk("drop_saturated", 32'(bus.drop_cnt), 32'd255);

    // reset at SCAN beat 50 aborts the readout
    send_frame(255, 12'h555);
    scan(1'b0, 50, 12'h555, 0);
    rst_n          = 1'b0;
    bus.disp_ready = 1'b1;
    tick();
    chk("abort_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("abort_disp_last", 32'(bus.disp_last), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_full", 32'(bus.buf_full), 32'd0);
    chk("abort_rd_clk_en", 32'(bus.ram_rd_clk_en), 32'd0);
    chk("abort_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    repeat (3) tick();
    chk("abort_scan_ignored", 32'(bus.busy), 32'd0);
    bus.disp_ready = 1'b0;

    // IDLE samples without sof are dropped
    for (int i = 0; i < 3; i++) begin
      bus.fft_valid = 1'b1;
      bus.fft_data  = 12'h123;
      tick();
    end
    bus.fft_valid = 1'b0;
    chk("idle_drop_cnt", 32'(bus.drop_cnt), 32'd3);
    chk("idle_drop_busy", 32'(bus.busy), 32'd0);

    send_frame(255, 12'h0AA);
    scan(1'b0, 256, 12'h0AA, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
